e203_lsu_ctrl_lite: RTL and testbench
=====================================

# e203_lsu_ctrl_lite

Downstream partner of the ALU's load/store address-generation unit. Accepts the AGU's ICB command stream, forwards it to one memory-side ICB port, and tracks outstanding transactions in an in-order FIFO. Each response is routed either back to the AGU (`back2agu`, used for AMO/unaligned sequences) or to the LSU writeback/commit port, with load-data alignment and sign/zero extension applied.

## Interface
- `OUTS_DEPTH`, 2: outstanding-transaction FIFO depth; 1, 2 or 4.
- `ADDR_SIZE`, `` `E203_ADDR_SIZE ``: address width.
- `XLEN`, `` `E203_XLEN ``: data width, 32.
- `ITAG_WIDTH`, `` `E203_ITAG_WIDTH ``: instruction tag width.
- `clk  in  1`: single clock. Everything is synchronous to `clk`.
- `rst_n  in  1`: synchronous, active-low reset.
- `agu_icb_cmd_valid/ready  in/out  1`: command handshake from the AGU.
- `agu_icb_cmd_addr  in  ADDR_SIZE`; `_read  in  1`; `_wdata  in  XLEN`; `_wmask  in  XLEN/8`; `_back2agu _lock _excl _usign  in  1`; `_size  in  2`; `_itag  in  ITAG_WIDTH`.
- `agu_icb_rsp_valid  out  1`; `agu_icb_rsp_ready  in  1`; `agu_icb_rsp_err _excl_ok  out  1`; `agu_icb_rsp_rdata  out  XLEN`: raw, unaligned response data.
- `lsu_o_valid  out  1`; `lsu_o_ready  in  1`: writeback/commit handshake.
- `lsu_o_wbck_wdat  out  XLEN`; `lsu_o_wbck_itag  out  ITAG_WIDTH`; `lsu_o_wbck_err  out  1`.
- `lsu_o_cmt_ld _st _buserr  out  1`; `lsu_o_cmt_badaddr  out  ADDR_SIZE`.
- `mem_icb_cmd_valid  out  1`; `mem_icb_cmd_ready  in  1`; `mem_icb_cmd_addr _read _wdata _wmask _lock _excl _size  out`: same widths as the AGU command.
- `mem_icb_rsp_valid  in  1`; `mem_icb_rsp_ready  out  1`; `mem_icb_rsp_err _excl_ok  in  1`; `mem_icb_rsp_rdata  in  XLEN`.
- `lsu_ctrl_active  out  1`: high when the FIFO is non-empty or `agu_icb_cmd_valid` is high. Used for clock-gating and idle detection.

## Operation
- **Command path** (combinational pass-through):
  - `mem_icb_cmd_valid = agu_icb_cmd_valid & ~full`.
  - `agu_icb_cmd_ready = mem_icb_cmd_ready & ~full`.
  - Payload fields are forwarded unchanged.
- **Push.** On a command fire, push `{addr, read, back2agu, size, usign, itag}` into the FIFO.
- **Full blocks push.** When the FIFO is full, a push is blocked even if a pop occurs in the same cycle. No same-cycle freeing of an entry.
- **Response routing.** Responses return in order; the FIFO head describes the current response.
  - If `head.back2agu`:
    - `agu_icb_rsp_valid = mem_icb_rsp_valid`.
    - `mem_icb_rsp_ready = agu_icb_rsp_ready`.
    - `lsu_o_valid = 0`.
  - Otherwise:
    - `lsu_o_valid = mem_icb_rsp_valid`.
    - `mem_icb_rsp_ready = lsu_o_ready`.
    - `agu_icb_rsp_valid = 0`.
- **Empty FIFO.** `mem_icb_rsp_ready = 0`, and both response-side valids are 0.
- **Pop.** Pop on a `mem_icb_rsp` fire.
- **Load alignment.** Compute `sh = rdata >> (8*head.addr[1:0])`.
  - Size `00` (byte): bits [7:0], extended by `usign` (zero-extend when `usign`=1, else sign-extend).
  - Size `01` (half): bits [15:0], extended the same way.
  - Size `10` (word): passed as-is.
  - For stores, `wbck_wdat` is 0.
- **Commit fields.**
  - `cmt_ld = head.read`; `cmt_st = ~head.read`.
  - `wbck_err = cmt_buserr = mem_icb_rsp_err`.
  - `cmt_badaddr = head.addr` (the full address, not masked).
  - `wbck_itag = head.itag`.
- **AGU response.** `agu_icb_rsp_rdata`, `_err` and `_excl_ok` pass through from `mem_icb_rsp`.
- **Occupancy counter.** Counts 0..OUTS_DEPTH. `full = (cnt == OUTS_DEPTH)`, `empty = (cnt == 0)`. Read and write pointers wrap modulo OUTS_DEPTH.

## Timing
- **Reset:** pointers = 0 and count = 0, so the FIFO is empty.
  - During and after reset: `lsu_o_valid = agu_icb_rsp_valid = mem_icb_rsp_ready = 0`.
  - `mem_icb_cmd_valid` follows `agu_icb_cmd_valid`.
  - `lsu_ctrl_active` follows `agu_icb_cmd_valid`.
- **Command latency:** zero cycles, combinational.
- **Response latency:** zero cycles from `mem_icb_rsp` to the selected output.
  - A response can be accepted no earlier than the cycle after its command fired, because the FIFO head registers at the clock edge.
- **Simultaneous push and pop:** when not full, both occur in the same cycle and the count is unchanged.
- **Reset mid-operation:** all outstanding entries are discarded. Responses arriving later for discarded entries are not accepted (`mem_icb_rsp_ready = 0`), because the FIFO is empty.
- **Valid stability:** valid/payload on the AGU and LSU response ports are stable while stalled, as long as `mem_icb_rsp` holds stable, per ICB rules.
- **Throughput:** with OUTS_DEPTH ≥ 2 and a 1-cycle memory, one transaction per cycle is sustained.

## Structure
- **Shared constants** belong in `e203_defines.v`:
  - ICB size encodings (`BYTE=2'b00`, `HALF=2'b01`, `WORD=2'b10`).
  - FIFO entry width = ADDR_SIZE + ITAG_WIDTH + 5.
- **Sub-module** `e203_lsu_outs_fifo`: synchronous FIFO with parameters `DEPTH` and `DW`.
  - Ports: push/pop strobes, `full`, `empty`, and a registered head output.
  - Same clock and same synchronous active-low reset.
- **Top level** holds the routing, the alignment/extension datapath and `lsu_ctrl_active`.

## Test plan
- **Signed byte load:** addr `0x1003`, size 00, `usign`=0, rdata `0x80FF_FF11` → `lsu_o_wbck_wdat = 0xFFFF_FF80`, `cmt_ld`=1, `err`=0.
- **Halfword load, zero-extended:** addr `0x2002`, size 01, `usign`=1, rdata `0xBEEF_1234` → `wdat = 0x0000_BEEF`. Repeating with `usign`=0 → `0xFFFF_BEEF`.
- **Back-to-back, full FIFO:** OUTS_DEPTH=2, memory withholding responses. Issue 3 commands → the third sees `agu_icb_cmd_ready`=0 until the first response fires; `lsu_ctrl_active`=1 throughout.
- **Routing:** a `back2agu`=1 read, then a `back2agu`=0 store.
  - First response appears only on `agu_icb_rsp` with raw rdata.
  - Second appears only on `lsu_o` with `cmt_st`=1.
  - Holding `lsu_o_ready`=0 stalls `mem_icb_rsp_ready`.
- **Bus error:** `mem_icb_rsp_err`=1 on a load to `0xDEAD_BEE0` → `lsu_o_wbck_err`=1, `cmt_buserr`=1, `cmt_badaddr = 0xDEAD_BEE0`.
- **Reset mid-operation:** `rst_n` low for 1 cycle with 2 outstanding entries → the following stale `mem_icb_rsp_valid` sees `ready`=0, `lsu_o_valid` stays 0, and a new command is accepted normally.

Source files
------------

// File: rtl/e203_lsu_ctrl_lite_pkg.sv
// Shared types and helpers for the LSU control slice: ICB size codes,
// outstanding-entry geometry and the load-data alignment/extension rule.
package e203_lsu_ctrl_lite_pkg;

    localparam int unsigned E203_ADDR_SIZE  = 32;
    localparam int unsigned E203_XLEN       = 32;
    localparam int unsigned E203_ITAG_WIDTH = 2;

    // read + back2agu + size[1:0] + usign
    localparam int unsigned OUTS_META_W = 5;

    typedef enum logic [1:0] {
        ICB_SIZE_BYTE = 2'b00,
        ICB_SIZE_HALF = 2'b01,
        ICB_SIZE_WORD = 2'b10
    } icb_size_e;

    function automatic int unsigned outs_entry_w(input int unsigned aw, input int unsigned iw);
        return aw + iw + OUTS_META_W;
    endfunction

    // Shift the raw bus word down to the addressed byte lane, then trim to the
    // access size and extend. Stores write back zero.
    function automatic logic [31:0] lsu_load_align(
        input logic [31:0] rdata,
        input logic [1:0]  ofs,
        input logic [1:0]  size,
        input logic        usign,
        input logic        read
    );
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {ofs, 3'b000};
        case (icb_size_e'(size))
            ICB_SIZE_BYTE: res = {{24{~usign & sh[7]}}, sh[7:0]};
            ICB_SIZE_HALF: res = {{16{~usign & sh[15]}}, sh[15:0]};
            default:       res = sh;
        endcase
        return read ? res : '0;
    endfunction

endpackage

// File: rtl/e203_lsu_ctrl_lite_outs.sv
// In-order outstanding-transaction FIFO. A push is refused while full even
// when a pop happens in the same cycle; the head is read straight from the
// storage registers so it only changes at a clock edge.
module e203_lsu_outs_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_en, pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];

    // Next pointers and occupancy; simultaneous push/pop leaves the count alone
    always_comb begin
        wptr_d = push_en ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop_en  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/count state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/e203_lsu_ctrl_lite.sv
// LSU control: forwards AGU ICB commands to memory, remembers each one in an
// in-order FIFO, and steers every response either back to the AGU or to the
// writeback/commit port with load alignment applied.
module e203_lsu_ctrl_lite
    import e203_lsu_ctrl_lite_pkg::*;
#(
    parameter int unsigned OUTS_DEPTH = 2,
    parameter int unsigned ADDR_SIZE  = E203_ADDR_SIZE,
    parameter int unsigned XLEN       = E203_XLEN,
    parameter int unsigned ITAG_WIDTH = E203_ITAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  agu_icb_cmd_valid,
    output logic                  agu_icb_cmd_ready,
    input  logic [ADDR_SIZE-1:0]  agu_icb_cmd_addr,
    input  logic                  agu_icb_cmd_read,
    input  logic [XLEN-1:0]       agu_icb_cmd_wdata,
    input  logic [XLEN/8-1:0]     agu_icb_cmd_wmask,
    input  logic                  agu_icb_cmd_back2agu,
    input  logic                  agu_icb_cmd_lock,
    input  logic                  agu_icb_cmd_excl,
    input  logic                  agu_icb_cmd_usign,
    input  logic [1:0]            agu_icb_cmd_size,
    input  logic [ITAG_WIDTH-1:0] agu_icb_cmd_itag,

    output logic                  agu_icb_rsp_valid,
    input  logic                  agu_icb_rsp_ready,
    output logic                  agu_icb_rsp_err,
    output logic                  agu_icb_rsp_excl_ok,
    output logic [XLEN-1:0]       agu_icb_rsp_rdata,

    output logic                  lsu_o_valid,
    input  logic                  lsu_o_ready,
    output logic [XLEN-1:0]       lsu_o_wbck_wdat,
    output logic [ITAG_WIDTH-1:0] lsu_o_wbck_itag,
    output logic                  lsu_o_wbck_err,
    output logic                  lsu_o_cmt_ld,
    output logic                  lsu_o_cmt_st,
    output logic                  lsu_o_cmt_buserr,
    output logic [ADDR_SIZE-1:0]  lsu_o_cmt_badaddr,

    output logic                  mem_icb_cmd_valid,
    input  logic                  mem_icb_cmd_ready,
    output logic [ADDR_SIZE-1:0]  mem_icb_cmd_addr,
    output logic                  mem_icb_cmd_read,
    output logic [XLEN-1:0]       mem_icb_cmd_wdata,
    output logic [XLEN/8-1:0]     mem_icb_cmd_wmask,
    output logic                  mem_icb_cmd_lock,
    output logic                  mem_icb_cmd_excl,
    output logic [1:0]            mem_icb_cmd_size,

    input  logic                  mem_icb_rsp_valid,
    output logic                  mem_icb_rsp_ready,
    input  logic                  mem_icb_rsp_err,
    input  logic                  mem_icb_rsp_excl_ok,
    input  logic [XLEN-1:0]       mem_icb_rsp_rdata,

    output logic                  lsu_ctrl_active
);

    localparam int unsigned EW = outs_entry_w(ADDR_SIZE, ITAG_WIDTH);

    logic                  full, empty;
    logic                  cmd_fire, rsp_fire;
    logic [EW-1:0]         push_ent, head_ent;
    logic [ADDR_SIZE-1:0]  head_addr;
    logic                  head_read, head_b2a, head_usign;
    logic [1:0]            head_size;
    logic [ITAG_WIDTH-1:0] head_itag;

    // Command path is a pure pass-through gated only by FIFO space
    assign mem_icb_cmd_valid = agu_icb_cmd_valid & ~full;
    assign agu_icb_cmd_ready = mem_icb_cmd_ready & ~full;
    assign mem_icb_cmd_addr  = agu_icb_cmd_addr;
    assign mem_icb_cmd_read  = agu_icb_cmd_read;
    assign mem_icb_cmd_wdata = agu_icb_cmd_wdata;
    assign mem_icb_cmd_wmask = agu_icb_cmd_wmask;
    assign mem_icb_cmd_lock  = agu_icb_cmd_lock;
    assign mem_icb_cmd_excl  = agu_icb_cmd_excl;
    assign mem_icb_cmd_size  = agu_icb_cmd_size;

    assign cmd_fire = agu_icb_cmd_valid & agu_icb_cmd_ready;
    assign rsp_fire = mem_icb_rsp_valid & mem_icb_rsp_ready;
    assign push_ent = {agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_back2agu,
                       agu_icb_cmd_size, agu_icb_cmd_usign, agu_icb_cmd_itag};

    e203_lsu_outs_fifo #(
        .DEPTH (OUTS_DEPTH),
        .DW    (EW)
    ) u_outs_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_fire),
        .din_i   (push_ent),
        .pop_i   (rsp_fire),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head_ent)
    );

    assign {head_addr, head_read, head_b2a, head_size, head_usign, head_itag} = head_ent;

    // Route the response by the head entry; nothing is accepted while empty
    always_comb begin
        agu_icb_rsp_valid = 1'b0;
        lsu_o_valid       = 1'b0;
        mem_icb_rsp_ready = 1'b0;
        if (!empty) begin
            if (head_b2a) begin
                agu_icb_rsp_valid = mem_icb_rsp_valid;
                mem_icb_rsp_ready = agu_icb_rsp_ready;
            end else begin
                lsu_o_valid       = mem_icb_rsp_valid;
                mem_icb_rsp_ready = lsu_o_ready;
            end
        end
    end

    assign agu_icb_rsp_rdata   = mem_icb_rsp_rdata;
    assign agu_icb_rsp_err     = mem_icb_rsp_err;
    assign agu_icb_rsp_excl_ok = mem_icb_rsp_excl_ok;

    assign lsu_o_wbck_wdat   = lsu_load_align(mem_icb_rsp_rdata, head_addr[1:0],
                                              head_size, head_usign, head_read);
    assign lsu_o_wbck_itag   = head_itag;
    assign lsu_o_wbck_err    = mem_icb_rsp_err;
    assign lsu_o_cmt_ld      = head_read;
    assign lsu_o_cmt_st      = ~head_read;
    assign lsu_o_cmt_buserr  = mem_icb_rsp_err;
    assign lsu_o_cmt_badaddr = head_addr;

    assign lsu_ctrl_active = ~empty | agu_icb_cmd_valid;

endmodule

// File: tb/tb_e203_lsu_ctrl_lite.sv
// Bench for e203_lsu_ctrl_lite: directed scenarios plus a randomized run
// checked against a queue-based model of the outstanding transactions.
module tb_e203_lsu_ctrl_lite;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned XW    = 32;
    localparam int unsigned IW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          agu_icb_cmd_valid = 0, agu_icb_cmd_ready;
    logic [AW-1:0] agu_icb_cmd_addr = 0;
    logic          agu_icb_cmd_read = 0;
    logic [XW-1:0] agu_icb_cmd_wdata = 0;
    logic [3:0]    agu_icb_cmd_wmask = 0;
    logic          agu_icb_cmd_back2agu = 0, agu_icb_cmd_lock = 0, agu_icb_cmd_excl = 0, agu_icb_cmd_usign = 0;
    logic [1:0]    agu_icb_cmd_size = 0;
    logic [IW-1:0] agu_icb_cmd_itag = 0;
    logic          agu_icb_rsp_valid, agu_icb_rsp_ready = 0, agu_icb_rsp_err, agu_icb_rsp_excl_ok;
    logic [XW-1:0] agu_icb_rsp_rdata;
    logic          lsu_o_valid, lsu_o_ready = 0;
    logic [XW-1:0] lsu_o_wbck_wdat;
    logic [IW-1:0] lsu_o_wbck_itag;
    logic          lsu_o_wbck_err, lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_buserr;
    logic [AW-1:0] lsu_o_cmt_badaddr;
    logic          mem_icb_cmd_valid, mem_icb_cmd_ready = 1;
    logic [AW-1:0] mem_icb_cmd_addr;
    logic          mem_icb_cmd_read;
    logic [XW-1:0] mem_icb_cmd_wdata;
    logic [3:0]    mem_icb_cmd_wmask;
    logic          mem_icb_cmd_lock, mem_icb_cmd_excl;
    logic [1:0]    mem_icb_cmd_size;
    logic          mem_icb_rsp_valid = 0, mem_icb_rsp_ready, mem_icb_rsp_err = 0, mem_icb_rsp_excl_ok = 0;
    logic [XW-1:0] mem_icb_rsp_rdata = 0;
    logic          lsu_ctrl_active;

    e203_lsu_ctrl_lite #(
        .OUTS_DEPTH (DEPTH),
        .ADDR_SIZE  (AW),
        .XLEN       (XW),
        .ITAG_WIDTH (IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .agu_icb_cmd_valid(agu_icb_cmd_valid), .agu_icb_cmd_ready(agu_icb_cmd_ready),
        .agu_icb_cmd_addr(agu_icb_cmd_addr), .agu_icb_cmd_read(agu_icb_cmd_read),
        .agu_icb_cmd_wdata(agu_icb_cmd_wdata), .agu_icb_cmd_wmask(agu_icb_cmd_wmask),
        .agu_icb_cmd_back2agu(agu_icb_cmd_back2agu), .agu_icb_cmd_lock(agu_icb_cmd_lock),
        .agu_icb_cmd_excl(agu_icb_cmd_excl), .agu_icb_cmd_usign(agu_icb_cmd_usign),
        .agu_icb_cmd_size(agu_icb_cmd_size), .agu_icb_cmd_itag(agu_icb_cmd_itag),
        .agu_icb_rsp_valid(agu_icb_rsp_valid), .agu_icb_rsp_ready(agu_icb_rsp_ready),
        .agu_icb_rsp_err(agu_icb_rsp_err), .agu_icb_rsp_excl_ok(agu_icb_rsp_excl_ok),
        .agu_icb_rsp_rdata(agu_icb_rsp_rdata),
        .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
        .lsu_o_wbck_wdat(lsu_o_wbck_wdat), .lsu_o_wbck_itag(lsu_o_wbck_itag),
        .lsu_o_wbck_err(lsu_o_wbck_err), .lsu_o_cmt_ld(lsu_o_cmt_ld),
        .lsu_o_cmt_st(lsu_o_cmt_st), .lsu_o_cmt_buserr(lsu_o_cmt_buserr),
        .lsu_o_cmt_badaddr(lsu_o_cmt_badaddr),
        .mem_icb_cmd_valid(mem_icb_cmd_valid), .mem_icb_cmd_ready(mem_icb_cmd_ready),
        .mem_icb_cmd_addr(mem_icb_cmd_addr), .mem_icb_cmd_read(mem_icb_cmd_read),
        .mem_icb_cmd_wdata(mem_icb_cmd_wdata), .mem_icb_cmd_wmask(mem_icb_cmd_wmask),
        .mem_icb_cmd_lock(mem_icb_cmd_lock), .mem_icb_cmd_excl(mem_icb_cmd_excl),
        .mem_icb_cmd_size(mem_icb_cmd_size),
        .mem_icb_rsp_valid(mem_icb_rsp_valid), .mem_icb_rsp_ready(mem_icb_rsp_ready),
        .mem_icb_rsp_err(mem_icb_rsp_err), .mem_icb_rsp_excl_ok(mem_icb_rsp_excl_ok),
        .mem_icb_rsp_rdata(mem_icb_rsp_rdata),
        .lsu_ctrl_active(lsu_ctrl_active)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          read;
        logic          b2a;
        logic [1:0]    size;
        logic          usign;
        logic [IW-1:0] itag;
    } ent_t;

    ent_t mq[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    // Expected writeback data from the access description alone
    function automatic logic [31:0] exp_wdat(input ent_t e, input logic [31:0] rd);
        int unsigned s, v;
        if (!e.read) return 32'h0;
        s = rd >> (8 * e.addr[1:0]);
        case (e.size)
            2'd0: begin v = s % 256;   if (!e.usign && v >= 128)   v = v + 32'hFFFF_FF00; end
            2'd1: begin v = s % 65536; if (!e.usign && v >= 32768) v = v + 32'hFFFF_0000; end
            default: v = s;
        endcase
        return v;
    endfunction

    // Drive one command and wait (bounded) for acceptance
    task automatic send_cmd(input logic [31:0] a, input logic rd, input logic b2a,
                            input logic [1:0] sz, input logic us, input logic [IW-1:0] tag,
                            output bit ok);
        ent_t e;
        ok = 0;
        @(negedge clk);
        agu_icb_cmd_valid = 1; agu_icb_cmd_addr = a; agu_icb_cmd_read = rd;
        agu_icb_cmd_back2agu = b2a; agu_icb_cmd_size = sz; agu_icb_cmd_usign = us;
        agu_icb_cmd_itag = tag; agu_icb_cmd_wdata = $urandom; agu_icb_cmd_wmask = 4'hF;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (agu_icb_cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            e.addr = a; e.read = rd; e.b2a = b2a; e.size = sz; e.usign = us; e.itag = tag;
            mq.push_back(e);
            #1;
        end
        agu_icb_cmd_valid = 0;
    endtask

    // Present a response; the caller inspects outputs before rsp_end
    task automatic rsp_drive(input logic [31:0] rd, input logic err, input logic aready, input logic lready);
        @(negedge clk);
        mem_icb_rsp_valid = 1; mem_icb_rsp_rdata = rd; mem_icb_rsp_err = err;
        mem_icb_rsp_excl_ok = 0; agu_icb_rsp_ready = aready; lsu_o_ready = lready;
        #1;
    endtask

    task automatic rsp_end();
        bit fire;
        fire = (mq.size() > 0) && (mq[0].b2a ? agu_icb_rsp_ready : lsu_o_ready);
        @(posedge clk);
        if (fire) void'(mq.pop_front());
        #1;
        mem_icb_rsp_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && mq.size() > 0; i++) begin
            rsp_drive($urandom, 0, 1, 1);
            rsp_end();
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk); @(negedge clk);
        #1;
        n_chk++;
        if ({lsu_o_valid, agu_icb_rsp_valid, mem_icb_rsp_ready, lsu_ctrl_active, mem_icb_cmd_valid} !== 5'b0)
            $display("FAIL reset_idle: got %b expected 00000",
                     {lsu_o_valid, agu_icb_rsp_valid, mem_icb_rsp_ready, lsu_ctrl_active, mem_icb_cmd_valid});
        else n_pass++;
        agu_icb_cmd_valid = 1;
        #1;
        n_chk++;
        if ({mem_icb_cmd_valid, lsu_ctrl_active, mem_icb_rsp_ready} !== 3'b110)
            $display("FAIL reset_follow: got %b expected 110", {mem_icb_cmd_valid, lsu_ctrl_active, mem_icb_rsp_ready});
        else n_pass++;
        @(posedge clk); #1;
        agu_icb_cmd_valid = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk); #1;
        n_chk++;
        if ({lsu_ctrl_active, mem_icb_rsp_ready} !== 2'b00)
            $display("FAIL reset_empty: got %b expected 00", {lsu_ctrl_active, mem_icb_rsp_ready});
        else n_pass++;
    endtask

    task automatic test_signed_byte();
        bit ok;
        send_cmd(32'h1003, 1, 0, 2'b00, 0, 2'd1, ok);
        n_chk++; if (!ok) $display("FAIL sbyte_accept: got 0 expected 1"); else n_pass++;
        rsp_drive(32'h80FF_FF11, 0, 0, 1);
        n_chk++;
        if (lsu_o_wbck_wdat !== 32'hFFFF_FF80) $display("FAIL sbyte_wdat: got %h expected ffffff80", lsu_o_wbck_wdat);
        else n_pass++;
        n_chk++;
        if ({lsu_o_valid, agu_icb_rsp_valid, lsu_o_cmt_ld, lsu_o_wbck_err, lsu_o_wbck_itag} !== 6'b101001)
            $display("FAIL sbyte_ctl: got %b expected 101001",
                     {lsu_o_valid, agu_icb_rsp_valid, lsu_o_cmt_ld, lsu_o_wbck_err, lsu_o_wbck_itag});
        else n_pass++;
        rsp_end();
    endtask

    task automatic test_half();
        bit ok;
        send_cmd(32'h2002, 1, 0, 2'b01, 1, 2'd2, ok);
        rsp_drive(32'hBEEF_1234, 0, 0, 1);
        n_chk++;
        if (lsu_o_wbck_wdat !== 32'h0000_BEEF) $display("FAIL half_zext: got %h expected 0000beef", lsu_o_wbck_wdat);
        else n_pass++;
        rsp_end();
        send_cmd(32'h2002, 1, 0, 2'b01, 0, 2'd3, ok);
        rsp_drive(32'hBEEF_1234, 0, 0, 1);
        n_chk++;
        if (lsu_o_wbck_wdat !== 32'hFFFF_BEEF) $display("FAIL half_sext: got %h expected ffffbeef", lsu_o_wbck_wdat);
        else n_pass++;
        rsp_end();
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        ent_t e;
        send_cmd(32'h100, 1, 0, 2'b10, 0, 2'd0, ok1);
        send_cmd(32'h104, 1, 0, 2'b10, 0, 2'd1, ok2);
        n_chk++;
        if ({ok1, ok2} !== 2'b11) $display("FAIL b2b_first_two: got %b expected 11", {ok1, ok2}); else n_pass++;
        @(negedge clk);
        agu_icb_cmd_valid = 1; agu_icb_cmd_addr = 32'h108; agu_icb_cmd_read = 1;
        agu_icb_cmd_back2agu = 0; agu_icb_cmd_size = 2'b10; agu_icb_cmd_usign = 0; agu_icb_cmd_itag = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({agu_icb_cmd_ready, mem_icb_cmd_valid, lsu_ctrl_active} !== 3'b001)
                $display("FAIL b2b_full_stall: got %b expected 001",
                         {agu_icb_cmd_ready, mem_icb_cmd_valid, lsu_ctrl_active});
            else n_pass++;
            @(negedge clk);
        end
        mem_icb_rsp_valid = 1; mem_icb_rsp_rdata = $urandom; mem_icb_rsp_err = 0; lsu_o_ready = 1;
        #1;
        n_chk++;
        if ({agu_icb_cmd_ready, mem_icb_rsp_ready} !== 2'b01)
            $display("FAIL b2b_pop_no_push: got %b expected 01", {agu_icb_cmd_ready, mem_icb_rsp_ready});
        else n_pass++;
        @(posedge clk);
        void'(mq.pop_front());
        @(negedge clk);
        mem_icb_rsp_valid = 0;
        #1;
        n_chk++;
        if ({agu_icb_cmd_ready, lsu_ctrl_active} !== 2'b11)
            $display("FAIL b2b_third_ready: got %b expected 11", {agu_icb_cmd_ready, lsu_ctrl_active});
        else n_pass++;
        @(posedge clk);
        e.addr = 32'h108; e.read = 1; e.b2a = 0; e.size = 2'b10; e.usign = 0; e.itag = 2'd2;
        mq.push_back(e);
        #1;
        agu_icb_cmd_valid = 0;
        drain();
        @(negedge clk); #1;
        n_chk++;
        if (lsu_ctrl_active !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", lsu_ctrl_active); else n_pass++;
    endtask

    task automatic test_routing();
        bit ok;
        send_cmd(32'h3001, 1, 1, 2'b10, 0, 2'd1, ok);
        send_cmd(32'h3004, 0, 0, 2'b10, 0, 2'd2, ok);
        rsp_drive(32'hCAFE_F00D, 0, 1, 1);
        n_chk++;
        if ({agu_icb_rsp_valid, lsu_o_valid, mem_icb_rsp_ready} !== 3'b101)
            $display("FAIL route_agu_sel: got %b expected 101", {agu_icb_rsp_valid, lsu_o_valid, mem_icb_rsp_ready});
        else n_pass++;
        n_chk++;
        if (agu_icb_rsp_rdata !== 32'hCAFE_F00D) $display("FAIL route_agu_raw: got %h expected cafef00d", agu_icb_rsp_rdata);
        else n_pass++;
        rsp_end();
        rsp_drive(32'h5555_AAAA, 0, 1, 0);
        n_chk++;
        if ({agu_icb_rsp_valid, lsu_o_valid, mem_icb_rsp_ready, lsu_o_cmt_st, lsu_o_cmt_ld} !== 5'b01010)
            $display("FAIL route_lsu_stall: got %b expected 01010",
                     {agu_icb_rsp_valid, lsu_o_valid, mem_icb_rsp_ready, lsu_o_cmt_st, lsu_o_cmt_ld});
        else n_pass++;
        n_chk++;
        if (lsu_o_wbck_wdat !== 32'h0) $display("FAIL route_store_wdat: got %h expected 0", lsu_o_wbck_wdat); else n_pass++;
        rsp_end();
        rsp_drive(32'h5555_AAAA, 0, 1, 1);
        n_chk++;
        if ({lsu_o_valid, mem_icb_rsp_ready} !== 2'b11)
            $display("FAIL route_lsu_release: got %b expected 11", {lsu_o_valid, mem_icb_rsp_ready});
        else n_pass++;
        rsp_end();
    endtask

    task automatic test_bus_error();
        bit ok;
        send_cmd(32'hDEAD_BEE0, 1, 0, 2'b10, 0, 2'd0, ok);
        rsp_drive(32'h0, 1, 0, 1);
        n_chk++;
        if ({lsu_o_valid, lsu_o_wbck_err, lsu_o_cmt_buserr} !== 3'b111)
            $display("FAIL buserr_flags: got %b expected 111", {lsu_o_valid, lsu_o_wbck_err, lsu_o_cmt_buserr});
        else n_pass++;
        n_chk++;
        if (lsu_o_cmt_badaddr !== 32'hDEAD_BEE0) $display("FAIL buserr_badaddr: got %h expected deadbee0", lsu_o_cmt_badaddr);
        else n_pass++;
        rsp_end();
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_cmd(32'h500, 1, 0, 2'b10, 0, 2'd0, ok);
        send_cmd(32'h504, 1, 1, 2'b10, 0, 2'd1, ok);
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        mq.delete();
        rsp_drive(32'h1111_2222, 0, 1, 1);
        n_chk++;
        if ({mem_icb_rsp_ready, lsu_o_valid, agu_icb_rsp_valid, lsu_ctrl_active} !== 4'b0000)
            $display("FAIL rstmid_stale: got %b expected 0000",
                     {mem_icb_rsp_ready, lsu_o_valid, agu_icb_rsp_valid, lsu_ctrl_active});
        else n_pass++;
        rsp_end();
        send_cmd(32'h4000, 1, 0, 2'b10, 0, 2'd3, ok);
        n_chk++; if (!ok) $display("FAIL rstmid_new_accept: got 0 expected 1"); else n_pass++;
        rsp_drive(32'h1234_5678, 0, 0, 1);
        n_chk++;
        if ({lsu_o_valid, lsu_o_wbck_wdat, lsu_o_wbck_itag} !== {1'b1, 32'h1234_5678, 2'd3})
            $display("FAIL rstmid_new_rsp: got %b/%h/%0d expected 1/12345678/3",
                     lsu_o_valid, lsu_o_wbck_wdat, lsu_o_wbck_itag);
        else n_pass++;
        rsp_end();
    endtask

    task automatic test_random();
        ent_t e, h;
        bit   full_m, empty_m, exp_lv, exp_av, exp_rdy, fire_c, fire_r;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            agu_icb_cmd_valid = $urandom_range(0, 1);
            agu_icb_cmd_addr = $urandom; agu_icb_cmd_read = $urandom_range(0, 1);
            agu_icb_cmd_wdata = $urandom; agu_icb_cmd_wmask = 4'($urandom);
            agu_icb_cmd_back2agu = ($urandom % 4) == 0; agu_icb_cmd_lock = $urandom_range(0, 1);
            agu_icb_cmd_excl = $urandom_range(0, 1); agu_icb_cmd_usign = $urandom_range(0, 1);
            agu_icb_cmd_size = 2'($urandom_range(0, 2)); agu_icb_cmd_itag = 2'($urandom);
            mem_icb_cmd_ready = ($urandom % 4) != 0;
            mem_icb_rsp_valid = $urandom_range(0, 1); mem_icb_rsp_rdata = $urandom;
            mem_icb_rsp_err = ($urandom % 8) == 0; mem_icb_rsp_excl_ok = $urandom_range(0, 1);
            agu_icb_rsp_ready = ($urandom % 4) != 0; lsu_o_ready = ($urandom % 4) != 0;
            #1;
            full_m  = (mq.size() == DEPTH);
            empty_m = (mq.size() == 0);
            n_chk++;
            if ({agu_icb_cmd_ready, mem_icb_cmd_valid, lsu_ctrl_active} !==
                {mem_icb_cmd_ready & ~full_m, agu_icb_cmd_valid & ~full_m, ~empty_m | agu_icb_cmd_valid})
                $display("FAIL rnd_cmd_hs c%0d: got %b expected %b", c,
                         {agu_icb_cmd_ready, mem_icb_cmd_valid, lsu_ctrl_active},
                         {mem_icb_cmd_ready & ~full_m, agu_icb_cmd_valid & ~full_m, ~empty_m | agu_icb_cmd_valid});
            else n_pass++;
            n_chk++;
            if ({mem_icb_cmd_addr, mem_icb_cmd_read, mem_icb_cmd_wdata, mem_icb_cmd_wmask,
                 mem_icb_cmd_lock, mem_icb_cmd_excl, mem_icb_cmd_size} !==
                {agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata, agu_icb_cmd_wmask,
                 agu_icb_cmd_lock, agu_icb_cmd_excl, agu_icb_cmd_size})
                $display("FAIL rnd_cmd_payload c%0d: got addr %h expected %h", c, mem_icb_cmd_addr, agu_icb_cmd_addr);
            else n_pass++;
            exp_lv = 0; exp_av = 0; exp_rdy = 0;
            if (!empty_m) begin
                h = mq[0];
                exp_lv  = mem_icb_rsp_valid & ~h.b2a;
                exp_av  = mem_icb_rsp_valid & h.b2a;
                exp_rdy = h.b2a ? agu_icb_rsp_ready : lsu_o_ready;
            end
            n_chk++;
            if ({lsu_o_valid, agu_icb_rsp_valid, mem_icb_rsp_ready} !== {exp_lv, exp_av, exp_rdy})
                $display("FAIL rnd_route c%0d: got %b expected %b", c,
                         {lsu_o_valid, agu_icb_rsp_valid, mem_icb_rsp_ready}, {exp_lv, exp_av, exp_rdy});
            else n_pass++;
            if (exp_lv) begin
                n_chk++;
                if ({lsu_o_wbck_wdat, lsu_o_wbck_itag, lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_wbck_err,
                     lsu_o_cmt_buserr, lsu_o_cmt_badaddr} !==
                    {exp_wdat(h, mem_icb_rsp_rdata), h.itag, h.read, ~h.read, mem_icb_rsp_err,
                     mem_icb_rsp_err, h.addr})
                    $display("FAIL rnd_wbck c%0d: got wdat %h addr %h expected wdat %h addr %h", c,
                             lsu_o_wbck_wdat, lsu_o_cmt_badaddr, exp_wdat(h, mem_icb_rsp_rdata), h.addr);
                else n_pass++;
            end
            if (exp_av) begin
                n_chk++;
                if ({agu_icb_rsp_rdata, agu_icb_rsp_err, agu_icb_rsp_excl_ok} !==
                    {mem_icb_rsp_rdata, mem_icb_rsp_err, mem_icb_rsp_excl_ok})
                    $display("FAIL rnd_agu_rsp c%0d: got %h expected %h", c, agu_icb_rsp_rdata, mem_icb_rsp_rdata);
                else n_pass++;
            end
            fire_r = exp_rdy & mem_icb_rsp_valid;
            fire_c = agu_icb_cmd_valid & mem_icb_cmd_ready & ~full_m;
            e.addr = agu_icb_cmd_addr; e.read = agu_icb_cmd_read; e.b2a = agu_icb_cmd_back2agu;
            e.size = agu_icb_cmd_size; e.usign = agu_icb_cmd_usign; e.itag = agu_icb_cmd_itag;
            @(posedge clk);
            if (fire_r) void'(mq.pop_front());
            if (fire_c) mq.push_back(e);
        end
        #1;
        agu_icb_cmd_valid = 0; mem_icb_rsp_valid = 0; mem_icb_cmd_ready = 1;
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_signed_byte();
        test_half();
        test_back_to_back();
        test_routing();
        test_bus_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
